// File: rtl/chip8_mem_arbiter.sv
// Three-way round-robin read arbiter and burst sequencer for the CHIP-8 byte memory.
// Walks a granted burst one byte per cycle and returns registered, id-tagged beats.
module chip8_mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int LW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [3*AW-1:0]  req_addr,
  input  logic [3*LW-1:0]  req_len,
  output logic [2:0]       gnt,
  output logic             busy,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_data,
  output logic             rd_valid,
  output logic [DW-1:0]    rd_data,
  output logic [1:0]       rd_id,
  output logic             rd_last
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [1:0]      rr_last;
  logic [1:0]      owner;
  logic [LW-1:0]   cnt;

  logic [1:0]      cand0, cand1, cand2, win;
  logic [AW-1:0]   win_addr;
  logic [LW-1:0]   win_len;
  logic            grant, beat;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Lengths above 16 saturate to a full 16-byte burst.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    if (len > LW'(16)) return LW'(16);
    return len;
  endfunction

  always_comb begin
    cand0 = next_idx(rr_last);
    cand1 = next_idx(cand0);
    cand2 = next_idx(cand1);
    if (req[cand0])      win = cand0;
    else if (req[cand1]) win = cand1;
    else                 win = cand2;
    win_addr = req_addr[win*AW +: AW];
    win_len  = clamp_len(req_len[win*LW +: LW]);
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant = 1'b1;
          if (win_len != '0) state_nxt = BURST;
        end
      end
      BURST: begin
        beat = 1'b1;
        if (cnt == LW'(1)) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == BURST);

  // Address stage drives mem_addr; the read stage captures mem_data one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last  <= 2'd2;
      owner    <= 2'd0;
      cnt      <= '0;
      gnt      <= '0;
      mem_addr <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_id    <= 2'd0;
      rd_last  <= 1'b0;
    end else begin
      gnt      <= '0;
      rd_valid <= beat;
      rd_last  <= beat && (cnt == LW'(1));
      if (grant) begin
        gnt     <= 3'b001 << win;
        rr_last <= win;
        owner   <= win;
        cnt     <= win_len;
        if (win_len != '0) mem_addr <= win_addr;
      end
      if (beat) begin
        rd_data <= mem_data;
        rd_id   <= owner;
        cnt     <= cnt - LW'(1);
        if (cnt != LW'(1)) mem_addr <= mem_addr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: directed table, hand sequences and random traffic,
// all shadowed by a transaction-level model that expands each grant into a beat queue.
module tb_chip8_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 5;
  localparam int NT = 7;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic          last;
  } beat_t;

  typedef struct {
    int rid;
    int addr;
    int len;
    int exp_beats;
    int exp_first;
    int exp_last;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req;
  logic [3*AW-1:0] req_addr;
  logic [3*LW-1:0] req_len;
  logic [2:0]      gnt;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [1:0]      rd_id;
  logic            rd_last;

  logic [DW-1:0]   mem [0:4095];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  chip8_mem_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .gnt      (gnt),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_id    (rd_id),
    .rd_last  (rd_last)
  );

  int            nvec = 0;
  int            nerr = 0;
  beat_t         q[$];
  int            m_rr;
  logic [2:0]    e_gnt;
  logic          e_rv;
  beat_t         e_beat;
  logic [AW-1:0] e_maddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input int addr, input int len);
    req_addr[i*AW +: AW] = AW'(addr);
    req_len[i*LW +: LW]  = LW'(len);
    req[i]               = 1'b1;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    int            w;
    int            n;
    logic [AW-1:0] a;
    logic          rst_edge;
    beat_t         b;
    rst_edge = !rst_n;
    e_gnt    = '0;
    e_rv     = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_rr    = 2;
      e_maddr = '0;
      e_beat  = '0;
    end else if (q.size() > 0) begin
      e_beat = q.pop_front();
      e_rv   = 1'b1;
    end else if (req != 3'b000) begin
      w = -1;
      for (int k = 1; k <= 3; k++)
        if (w < 0 && req[(m_rr + k) % 3]) w = (m_rr + k) % 3;
      e_gnt = 3'(1 << w);
      m_rr  = w;
      n = int'(req_len[w*LW +: LW]);
      if (n > 16) n = 16;
      a = req_addr[w*AW +: AW];
      for (int k = 0; k < n; k++) begin
        b.addr = a + AW'(k);
        b.data = mem[a + AW'(k)];
        b.id   = 2'(w);
        b.last = (k == n - 1);
        q.push_back(b);
      end
    end
    if (q.size() > 0) e_maddr = q[0].addr;
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("rd_valid", 32'(rd_valid), 32'(e_rv));
    chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
    if (e_rv || rst_edge) begin
      chk("rd_data", 32'(rd_data), 32'(e_beat.data));
      chk("rd_id", 32'(rd_id), 32'(e_beat.id));
      chk("rd_last", 32'(rd_last), 32'(e_beat.last));
    end
  endtask

  vec_t       tbl [NT];
  logic [2:0] g;
  int         waited, got_beats, got_busy, got_first, got_laddr, got_lasts;
  int         ng, gi, g1cnt;

  initial begin
    tbl[0] = '{1, 'hFFE, 4, 4, 'hFFE, 'h001};
    tbl[1] = '{2, 'h300, 0, 0, 0, 0};
    tbl[2] = '{2, 'h100, 20, 16, 'h100, 'h10F};
    tbl[3] = '{0, 'h000, 1, 1, 'h000, 'h000};
    tbl[4] = '{1, 'hABC, 16, 16, 'hABC, 'hACB};
    tbl[5] = '{0, 'hFF0, 31, 16, 'hFF0, 'hFFF};
    tbl[6] = '{2, 'h7FF, 2, 2, 'h7FF, 'h800};

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h200] = 8'h12;
    mem[12'h201] = 8'h34;
    rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic two-byte opcode fetch
    set_req(0, 'h200, 2);
    tick(); chk("t1_gnt", 32'(gnt), 32'b001);
    req[0] = 1'b0;
    chk("t1_busy_a", 32'(busy), 32'd1);
    chk("t1_addr_a", 32'(mem_addr), 32'h200);
    tick();
    chk("t1_rv_a", 32'(rd_valid), 32'd1); chk("t1_data_a", 32'(rd_data), 32'h12);
    chk("t1_last_a", 32'(rd_last), 32'd0); chk("t1_busy_b", 32'(busy), 32'd1);
    chk("t1_addr_b", 32'(mem_addr), 32'h201);
    tick();
    chk("t1_rv_b", 32'(rd_valid), 32'd1); chk("t1_data_b", 32'(rd_data), 32'h34);
    chk("t1_last_b", 32'(rd_last), 32'd1); chk("t1_id_b", 32'(rd_id), 32'd0);
    chk("t1_busy_c", 32'(busy), 32'd0);
    tick();
    chk("t1_rv_c", 32'(rd_valid), 32'd0);

    // Single-requester table: wrap, zero length, clamping
    for (int v = 0; v < NT; v++) begin
      set_req(tbl[v].rid, tbl[v].addr, tbl[v].len);
      g = '0; waited = 0;
      while (g == 3'b000 && waited < 8) begin
        tick(); g = gnt; waited++;
      end
      chk("tbl_gnt", 32'(g), 32'(1 << tbl[v].rid));
      req[tbl[v].rid] = 1'b0;
      got_beats = 0; got_busy = 0; got_first = -1; got_laddr = -1; got_lasts = 0;
      for (int c = 0; c < 24; c++) begin
        if (busy) begin
          if (got_first < 0) got_first = int'(mem_addr);
          got_laddr = int'(mem_addr);
          got_busy++;
        end
        if (rd_valid) begin
          got_beats++;
          if (rd_last) got_lasts++;
        end
        tick();
      end
      chk("tbl_beats", 32'(got_beats), 32'(tbl[v].exp_beats));
      chk("tbl_busy", 32'(got_busy), 32'(tbl[v].exp_beats));
      chk("tbl_lasts", 32'(got_lasts), 32'(tbl[v].exp_beats > 0 ? 1 : 0));
      if (tbl[v].exp_beats > 0) begin
        chk("tbl_first", 32'(got_first), 32'(tbl[v].exp_first));
        chk("tbl_laddr", 32'(got_laddr), 32'(tbl[v].exp_last));
      end
    end

    // Three simultaneous requesters, two rounds
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      set_req(0, 'h010, 1); set_req(1, 'h020, 1); set_req(2, 'h030, 1);
      ng = 0;
      for (int c = 0; c < 20 && ng < 3; c++) begin
        tick();
        if (gnt != 3'b000) begin
          chk("rot_onehot", 32'($onehot(gnt)), 32'd1);
          gi = gnt[0] ? 0 : (gnt[1] ? 1 : 2);
          chk("rot_order", 32'(gi), 32'(ng));
          req[gi] = 1'b0;
          ng++;
        end
      end
      chk("rot_count", 32'(ng), 32'd3);
      repeat (4) tick();
    end

    // Reset during beat 3 of a 10-beat burst
    set_req(0, 'h400, 10);
    tick(); chk("mr_gnt", 32'(gnt), 32'b001);
    req[0] = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mr_rv", 32'(rd_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    set_req(1, 'h500, 2); set_req(0, 'h600, 2);
    tick(); chk("mr_first", 32'(gnt), 32'b001);
    req[0] = 1'b0;
    ng = 0;
    for (int c = 0; c < 10 && ng == 0; c++) begin
      tick();
      if (gnt[1]) ng = 1;
    end
    chk("mr_second", 32'(ng), 32'd1);
    req[1] = 1'b0;
    repeat (4) tick();

    // A request pulsed during someone else's burst is never granted
    set_req(0, 'h700, 8);
    tick(); chk("wd_gnt", 32'(gnt), 32'b001);
    req[0] = 1'b0;
    tick();
    set_req(1, 'h710, 3);
    tick();
    req[1] = 1'b0;
    g1cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (gnt[1]) g1cnt++;
    end
    chk("wd_never", 32'(g1cnt), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (req[i] && gnt[i])
          req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 49) == 0)
          req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0)
          set_req(i, int'($urandom_range(0, 4095)), int'($urandom_range(0, 20)));
      end
      tick();
    end
    rst_n = 1'b1;
    req = '0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
